// File: rtl/regfile_seq_if.sv
// Bus between instruction fetch, the regfile_seq sequencer and the 8x16 register file.
// The sequencer takes the slave side; fetch plus the register file take the master side.
interface regfile_seq_if;
    logic        s;
    logic [15:0] instr;
    logic        w;
    logic        write;
    logic [2:0]  writenum;
    logic [2:0]  readnum;
    logic [15:0] rf_wdata;
    logic [15:0] rf_rdata;
    logic [15:0] c_out;
    logic [2:0]  status;
    logic        err;

    modport master (
        output s, instr, rf_rdata,
        input  w, write, writenum, readnum, rf_wdata, c_out, status, err
    );

    modport slave (
        input  s, instr, rf_rdata,
        output w, write, writenum, readnum, rf_wdata, c_out, status, err
    );
endinterface

// File: rtl/regfile_seq.sv
// Instruction sequencer for the 8x16 register file: one micro-step per clock.
// Handles MOV imm, MOV reg, ADD, CMP, AND and MVN using the A/B operand latches and C result register.
module regfile_seq (
    input  logic          clk,
    input  logic          reset_n,
    regfile_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_DECODE,
        ST_WIMM,
        ST_GETA,
        ST_GETB,
        ST_EXEC,
        ST_WB
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [15:0] ir;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] c_q;
    logic [2:0]  status_q;

    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [2:0]  rm;
    logic [15:0] imm_sext;

    logic        is_movi;
    logic        is_movr;
    logic        is_alu;
    logic        is_cmp;
    logic        is_mvn;

    logic        accept;
    logic        ld_a;
    logic        ld_b;
    logic        ld_c;
    logic        ld_status;

    logic [15:0] alu_res;
    logic        alu_ovf;

    assign opcode   = ir[15:13];
    assign op       = ir[12:11];
    assign rn       = ir[10:8];
    assign rd       = ir[7:5];
    assign rm       = ir[2:0];
    assign imm_sext = {{8{ir[7]}}, ir[7:0]};

    assign is_movi = (opcode == 3'b110) && (op == 2'b10);
    assign is_movr = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu  = (opcode == 3'b101);
    assign is_cmp  = is_alu && (op == 2'b01);
    assign is_mvn  = is_alu && (op == 2'b11);

    assign accept  = (state == ST_WAIT) && bus.s;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_WAIT;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        state_nxt = state;
        unique case (state)
            ST_WAIT:   if (bus.s) state_nxt = ST_DECODE;
            ST_DECODE: begin
                if (is_movi)                state_nxt = ST_WIMM;
                else if (is_movr || is_mvn) state_nxt = ST_GETB;
                else if (is_alu)            state_nxt = ST_GETA;
                else                        state_nxt = ST_WAIT;
            end
            ST_WIMM:   state_nxt = ST_WAIT;
            ST_GETA:   state_nxt = ST_GETB;
            ST_GETB:   state_nxt = ST_EXEC;
            ST_EXEC:   state_nxt = is_cmp ? ST_WAIT : ST_WB;
            ST_WB:     state_nxt = ST_WAIT;
            default:   state_nxt = ST_WAIT;
        endcase
    end

    // Per-state outputs and datapath load enables.
    always_comb begin
        bus.w        = 1'b0;
        bus.write    = 1'b0;
        bus.writenum = 3'd0;
        bus.readnum  = 3'd0;
        bus.rf_wdata = 16'd0;
        bus.err      = 1'b0;
        ld_a         = 1'b0;
        ld_b         = 1'b0;
        ld_c         = 1'b0;
        ld_status    = 1'b0;
        unique case (state)
            ST_WAIT:   bus.w = 1'b1;
            ST_DECODE: bus.err = !(is_movi || is_movr || is_alu);
            ST_WIMM: begin
                bus.write    = 1'b1;
                bus.writenum = rn;
                bus.rf_wdata = imm_sext;
            end
            ST_GETA: begin
                bus.readnum = rn;
                ld_a        = 1'b1;
            end
            ST_GETB: begin
                bus.readnum = rm;
                ld_b        = 1'b1;
            end
            ST_EXEC: begin
                ld_c      = !is_cmp;
                ld_status = is_cmp;
            end
            ST_WB: begin
                bus.write    = 1'b1;
                bus.writenum = rd;
                bus.rf_wdata = c_q;
            end
            default: bus.w = 1'b0;
        endcase
    end

    // ALU: MOV reg passes B; CMP shares the subtractor whose overflow feeds status V.
    always_comb begin
        alu_res = b_q;
        if (is_alu) begin
            unique case (op)
                2'b00: alu_res = a_q + b_q;
                2'b01: alu_res = a_q - b_q;
                2'b10: alu_res = a_q & b_q;
                2'b11: alu_res = ~b_q;
                default: alu_res = b_q;
            endcase
        end
    end

    assign alu_ovf = (a_q[15] ^ b_q[15]) & (alu_res[15] ^ a_q[15]);

    // Instruction latch, operand latches, result and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: these are a handful of architectural flops, so all of them reset; a reset abandons any in-flight instruction.
            ir       <= 16'd0;
            a_q      <= 16'd0;
            b_q      <= 16'd0;
            c_q      <= 16'd0;
            status_q <= 3'd0;
        end else begin
            if (accept)    ir       <= bus.instr;
            if (ld_a)      a_q      <= bus.rf_rdata;
            if (ld_b)      b_q      <= bus.rf_rdata;
            if (ld_c)      c_q      <= alu_res;
            if (ld_status) status_q <= {alu_res == 16'd0, alu_res[15], alu_ovf};
        end
    end

    assign bus.c_out  = c_q;
    assign bus.status = status_q;

endmodule

// File: tb/tb_regfile_seq.sv
// Self-checking bench for regfile_seq: a register file model plus a write scoreboard.
// Expected writes are queued when an instruction is issued and popped when a write pulse appears.
module tb_regfile_seq;

    typedef struct packed {
        logic [2:0]  num;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    always #5 clk = ~clk;

    regfile_seq_if bus ();

    regfile_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Register file model: DUT writes, plus bench pokes for preloading while idle.
    logic [15:0] rf [8];
    logic        tb_we = 1'b0;
    logic [2:0]  tb_wnum = 3'd0;
    logic [15:0] tb_wdata = 16'd0;

    assign bus.rf_rdata = rf[bus.readnum];

    always @(posedge clk) begin
        if (bus.write)  rf[bus.writenum] <= bus.rf_wdata;
        else if (tb_we) rf[tb_wnum]      <= tb_wdata;
    end

    int  passed = 0;
    int  total  = 0;
    int  wr_cnt = 0;
    int  err_cnt = 0;
    bit  saw_r7 = 1'b0;
    wr_t exp_q[$];
    wr_t mon_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] movi(input logic [2:0] n, input logic [7:0] imm);
        return {3'b110, 2'b10, n, imm};
    endfunction

    function automatic logic [15:0] movr(input logic [2:0] d, input logic [2:0] m);
        return {3'b110, 2'b00, 3'b000, d, 2'b00, m};
    endfunction

    function automatic logic [15:0] alu(input logic [1:0] o, input logic [2:0] n,
                                        input logic [2:0] d, input logic [2:0] m);
        return {3'b101, o, n, d, 2'b00, m};
    endfunction

    task automatic push(input logic [2:0] n, input logic [15:0] d);
        wr_t e;
        e.num  = n;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic poke(input logic [2:0] n, input logic [15:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_wnum = n; tb_wdata = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // One start handshake, then count cycles with w=0 (bounded).
    task automatic issue(input logic [15:0] ins, input int exp_busy, input string tag);
        int busy;
        @(negedge clk);
        bus.s = 1'b1; bus.instr = ins;
        @(negedge clk);
        bus.s = 1'b0; bus.instr = 16'hFFFF;
        busy = 0;
        while (!bus.w && busy < 20) begin
            busy++;
            @(negedge clk);
        end
        check({tag, "_busy"}, busy, exp_busy);
    endtask

    // Write monitor / scoreboard consumer, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.write) begin
            wr_cnt++;
            check("write_in_wait", {31'd0, bus.w}, 32'd0);
            check("write_pending", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("writenum", {29'd0, bus.writenum}, {29'd0, mon_e.num});
                check("rf_wdata", {16'd0, bus.rf_wdata}, {16'd0, mon_e.data});
            end
        end
        if (bus.err) err_cnt++;
        if (!bus.w && bus.readnum == 3'd7) saw_r7 = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        int e0;
        bus.s = 1'b0;
        bus.instr = 16'd0;
        #1 reset_n = 1'b0;
        for (int i = 0; i < 8; i++) poke(i[2:0], 16'd0);

        check("rst_w",       {31'd0, bus.w},       32'd1);
        check("rst_write",   {31'd0, bus.write},   32'd0);
        check("rst_c_out",   {16'd0, bus.c_out},   32'd0);
        check("rst_status",  {29'd0, bus.status},  32'd0);
        check("rst_err",     {31'd0, bus.err},     32'd0);
        check("rst_readnum", {29'd0, bus.readnum}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        poke(3'd1, 16'h7FFF);
        poke(3'd2, 16'h0001);

        // MOV R3,#0xF0
        push(3'd3, 16'hFFF0);
        issue(16'hD3F0, 2, "movi_r3");
        check("movi_wrcnt", wr_cnt, 1);
        check("r3_val", {16'd0, rf[3]}, 32'h0000_FFF0);

        // ADD R4,R1,R2: wraps into the sign bit, status untouched
        push(3'd4, 16'h8000);
        issue(alu(2'b00, 3'd1, 3'd4, 3'd2), 5, "add");
        check("add_c_out",  {16'd0, bus.c_out},  32'h0000_8000);
        check("add_status", {29'd0, bus.status}, 32'd0);

        // AND R0,R1,R3
        push(3'd0, 16'h7FF0);
        issue(alu(2'b10, 3'd1, 3'd0, 3'd3), 5, "and");
        check("and_c_out", {16'd0, bus.c_out}, 32'h0000_7FF0);

        // MOV R2,#0xFF sign-extends to 0xFFFF
        push(3'd2, 16'hFFFF);
        issue(movi(3'd2, 8'hFF), 2, "movi_r2");

        // CMP R1,R2: 0x7FFF - (-1) overflows
        w0 = wr_cnt;
        issue(alu(2'b01, 3'd1, 3'd6, 3'd2), 4, "cmp");
        check("cmp_status",  {29'd0, bus.status}, 32'b011);
        check("cmp_nowrite", wr_cnt, w0);
        check("cmp_c_keep",  {16'd0, bus.c_out},  32'h0000_7FF0);

        // MVN R5,R2 with Rn field = 7 to spot any GETA visit
        poke(3'd2, 16'h00FF);
        saw_r7 = 1'b0;
        push(3'd5, 16'hFF00);
        issue(alu(2'b11, 3'd7, 3'd5, 3'd2), 4, "mvn");
        check("mvn_no_geta", {31'd0, saw_r7},    32'd0);
        check("mvn_c_out",   {16'd0, bus.c_out}, 32'h0000_FF00);

        // MOV R7,R3
        push(3'd7, 16'hFFF0);
        issue(movr(3'd7, 3'd3), 4, "movr");
        check("r7_val", {16'd0, rf[7]}, 32'h0000_FFF0);

        // Unsupported opcode
        e0 = err_cnt;
        w0 = wr_cnt;
        issue(16'hE000, 1, "unsup");
        check("unsup_err_pulses", err_cnt - e0, 1);
        check("unsup_nowrite",    wr_cnt, w0);

        // s held high: back-to-back MOV imm, one per 3 cycles
        w0 = wr_cnt;
        repeat (3) push(3'd6, 16'h0012);
        @(negedge clk);
        bus.s = 1'b1; bus.instr = movi(3'd6, 8'h12);
        repeat (9) @(negedge clk);
        bus.s = 1'b0;
        check("b2b_writes", wr_cnt - w0, 3);
        check("b2b_idle",   {31'd0, bus.w}, 32'd1);

        // Reset during the EXEC of ADD R5,R1,R2
        w0 = wr_cnt;
        @(negedge clk);
        bus.s = 1'b1; bus.instr = alu(2'b00, 3'd1, 3'd5, 3'd2);
        @(negedge clk);
        bus.s = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_status", {29'd0, bus.status}, 32'b011);
        reset_n = 1'b0;
        #1;
        check("mid_rst_w",      {31'd0, bus.w},      32'd1);
        check("mid_rst_write",  {31'd0, bus.write},  32'd0);
        check("mid_rst_c_out",  {16'd0, bus.c_out},  32'd0);
        check("mid_rst_status", {29'd0, bus.status}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_r5_kept",  {16'd0, rf[5]}, 32'h0000_FF00);
        check("rst_nowrite",  wr_cnt, w0);

        // Recovery after reset
        push(3'd3, 16'hFF80);
        issue(movi(3'd3, 8'h80), 2, "movi_after_rst");
        check("r3_after_rst", {16'd0, rf[3]}, 32'h0000_FF80);

        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
